// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE core pipeline control.
// Contents: opcode field constants, the control FSM state type, the scoreboard
// entry and source-register records, and the decode helpers dst_of / srcs_of / is_hlt.
package simple_pkg;

  // Major opcode, bits 15:14.
  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b11;
  // Immediate/branch group, bits 15:11.
  localparam logic [4:0] OP_LI  = 5'b10000;
  localparam logic [4:0] OP_B   = 5'b10100;
  localparam logic [4:0] OP_BCC = 5'b10111;
  // Arithmetic sub-op, bits 7:4, that write no register.
  localparam logic [3:0] ALU_CMP = 4'b0101;
  localparam logic [3:0] ALU_OUT = 4'b1101;
  localparam logic [3:0] ALU_HLT = 4'b1111;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted
  } state_t;

  typedef struct packed {
    logic       v;
    logic [2:0] dest;
    logic       ld;
  } sb_entry_t;

  typedef struct packed {
    logic       va;
    logic [2:0] ra;
    logic       vb;
    logic [2:0] rb;
  } srcs_t;

  // Destination register written by an instruction, tagged if it is a load.
  function automatic sb_entry_t dst_of(logic [15:0] instr);
    dst_of = '0;
    if (instr[15:14] == OP_LD) begin
      dst_of.v    = 1'b1;
      dst_of.dest = instr[13:11];
      dst_of.ld   = 1'b1;
    end else if (instr[15:11] == OP_LI) begin
      dst_of.v    = 1'b1;
      dst_of.dest = instr[10:8];
    end else if (instr[15:14] == OP_ALU && instr[7:4] != ALU_CMP &&
                 instr[7:4] != ALU_OUT && instr[7:4] != ALU_HLT) begin
      dst_of.v    = 1'b1;
      dst_of.dest = instr[10:8];
    end
  endfunction

  // Registers read by an instruction.
  function automatic srcs_t srcs_of(logic [15:0] instr);
    srcs_of = '0;
    if (instr[15:11] != OP_LI && instr[15:11] != OP_B && instr[15:11] != OP_BCC) begin
      unique case (instr[15:14])
        OP_LD: begin
          srcs_of.vb = 1'b1;
          srcs_of.rb = instr[10:8];
        end
        OP_ST, OP_ALU: begin
          srcs_of.va = 1'b1;
          srcs_of.ra = instr[13:11];
          srcs_of.vb = 1'b1;
          srcs_of.rb = instr[10:8];
        end
        default: srcs_of = '0;
      endcase
    end
  endfunction

  function automatic logic is_hlt(logic [15:0] instr);
    return (instr[15:14] == OP_ALU) && (instr[7:4] == ALU_HLT);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and hazard_ctrl.
// master: datapath side (drives ID/EX status and resume, receives controls).
// slave:  hazard_ctrl side.
interface hazard_ctrl_if;
  logic        id_valid;
  logic [15:0] id_instr;
  logic        ex_valid;
  logic        ex_jflag;
  logic        resume;
  logic        stall_if;
  logic        stall_id;
  logic        bubble_ex;
  logic        flush;
  logic        halted;

  modport master (
    output id_valid, id_instr, ex_valid, ex_jflag, resume,
    input  stall_if, stall_id, bubble_ex, flush, halted
  );

  modport slave (
    input  id_valid, id_instr, ex_valid, ex_jflag, resume,
    output stall_if, stall_id, bubble_ex, flush, halted
  );
endinterface

// File: rtl/sb_shift.sv
// Three-entry in-flight write scoreboard (EX, MEM, WB), shifted every cycle.
// Ports: clk, rst (sync, active-high); i_push = entry entering EX;
// i_srcs = registers read by the ID instruction; o_match = ID must stall.
module sb_shift
  import simple_pkg::*;
#(
  parameter int unsigned FWD = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  sb_entry_t i_push,
  input  srcs_t     i_srcs,
  output logic      o_match
);

  sb_entry_t r_ex, r_mem, r_wb;
  logic      w_hit_ex, w_hit_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= i_push;
    end
  end

  function automatic logic hit(sb_entry_t e, srcs_t s);
    return e.v & ((s.va & (s.ra == e.dest)) | (s.vb & (s.rb == e.dest)));
  endfunction

  assign w_hit_ex  = hit(r_ex, i_srcs);
  assign w_hit_mem = hit(r_mem, i_srcs);

  // With forwarding only a load in EX cannot supply its result in time.
  // WB never matters: the register file writes before it reads.
  always_comb begin
    o_match = 1'b0;
    if (FWD != 0) o_match = w_hit_ex & r_ex.ld;
    else          o_match = w_hit_ex | w_hit_mem;
  end

  logic w_unused_sb;
  assign w_unused_sb = ^{r_wb, r_mem.ld};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control for the SIMPLE 5-stage core: stall/bubble/flush generation,
// scoreboard-based hazard detection and the HLT drain/halt/resume sequencer.
// Ports: clk, rst (sync, active-high); bus (slave) carries ID/EX status, resume
// and the stall_if/stall_id/bubble_ex/flush/halted controls.
module hazard_ctrl
  import simple_pkg::*;
#(
  parameter int unsigned FWD          = 1,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  localparam int unsigned CntW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(DRAIN_CYCLES - 1);

  state_t          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            w_flush, w_match, w_issue;
  logic            w_stall_if, w_stall_id, w_bubble_ex, w_halted;
  srcs_t           w_srcs;
  sb_entry_t       w_push;

  assign w_srcs  = srcs_of(bus.id_instr);
  assign w_flush = bus.ex_valid & bus.ex_jflag;
  // A flushed or held instruction enters EX as an invalid entry.
  assign w_push  = w_issue ? dst_of(bus.id_instr) : '0;

  sb_shift #(
    .FWD(FWD)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_srcs (w_srcs),
    .o_match(w_match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StRun;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_issue     = 1'b0;
    w_stall_if  = 1'b0;
    w_stall_id  = 1'b0;
    w_bubble_ex = 1'b0;
    w_halted    = 1'b0;
    unique case (r_state)
      StRun: begin
        if (bus.id_valid & w_match) begin
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_bubble_ex = 1'b1;
        end
        w_issue = bus.id_valid & ~w_stall_id & ~w_flush;
        if (w_issue & is_hlt(bus.id_instr)) begin
          w_state_d = StDrain;
          w_cnt_d   = CntLoad;
        end
      end
      StDrain: begin
        // Whatever sits in IF/ID behind the HLT is discarded.
        w_stall_if  = 1'b1;
        w_bubble_ex = 1'b1;
        if (r_cnt == '0) w_state_d = StHalted;
        else             w_cnt_d   = r_cnt - CntW'(1);
      end
      StHalted: begin
        w_halted    = 1'b1;
        w_stall_if  = 1'b1;
        w_stall_id  = 1'b1;
        w_bubble_ex = 1'b1;
        if (bus.resume) w_state_d = StRun;
      end
      default: w_state_d = StRun;
    endcase
    // A taken branch overrides every hold request.
    if (w_flush) begin
      w_stall_if  = 1'b0;
      w_stall_id  = 1'b0;
      w_bubble_ex = 1'b0;
    end
  end

  assign bus.stall_if  = w_stall_if;
  assign bus.stall_id  = w_stall_id;
  assign bus.bubble_ex = w_bubble_ex;
  assign bus.flush     = w_flush;
  assign bus.halted    = w_halted;

  logic w_unused_instr;
  assign w_unused_instr = ^bus.id_instr[3:0];

endmodule
